// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, glitch-rejecting start, optional parity, 1/2 stop bits.
// o_valid strobes one clock after the last stop sample; no flow control, so each new word overwrites the last.
module uart_rx_param #(
  parameter int NB_DATA = 8,
  parameter int N_TICKS = 16,
  parameter int PARITY  = 0,
  parameter int N_STOP  = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_busy
);

  localparam int CW = $clog2(N_TICKS);
  localparam int BW = $clog2(NB_DATA + 1);
  localparam logic [CW-1:0] HALF  = CW'(N_TICKS / 2 - 1);
  localparam logic [CW-1:0] LAST  = CW'(N_TICKS - 1);
  localparam logic [BW-1:0] DLAST = BW'(NB_DATA - 1);
  localparam logic [BW-1:0] SLAST = BW'(N_STOP - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [NB_DATA-1:0]   sr_q, sr_d;
  logic                 armed_q, armed_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_meta_q, rx_s_q;
  logic [NB_DATA-1:0]   data_q;
  logic                 valid_q, perr_out_q, ferr_out_q;
  logic                 done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      armed_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      armed_q    <= armed_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      rx_meta_q  <= i_rx;
      rx_s_q     <= rx_meta_q;
      valid_q    <= done;
      if (done) begin
        data_q     <= sr_q;
        perr_out_q <= perr_q;
        ferr_out_q <= ferr_d;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    armed_d    = armed_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        // Only a line seen high re-arms, so a held break cannot retrigger.
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = S_START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (i_tick) begin
          if (tick_cnt_q == HALF) begin
            tick_cnt_d = '0;
            state_d    = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (i_tick) begin
          if (tick_cnt_q == LAST) begin
            tick_cnt_d = '0;
            sr_d       = {rx_s_q, sr_q[NB_DATA-1:1]};
            if (bit_cnt_q == DLAST) begin
              bit_cnt_d = '0;
              state_d   = (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (i_tick) begin
          if (tick_cnt_q == LAST) begin
            tick_cnt_d = '0;
            perr_d     = (PARITY == 1) ? (^sr_q ^ rx_s_q) : ~(^sr_q ^ rx_s_q);
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (i_tick) begin
          if (tick_cnt_q == LAST) begin
            tick_cnt_d = '0;
            if (!rx_s_q) begin
              ferr_d  = 1'b1;
              armed_d = 1'b0;
            end
            if (bit_cnt_q == SLAST) begin
              bit_cnt_d = '0;
              state_d   = S_IDLE;
              done      = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_out_q;
  assign o_frame_err  = ferr_out_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default 8N1, even-parity and odd-parity/7-bit/2-stop instances.
// Ticks every 8 clocks (16 ticks per bit); line driven just after posedge, outputs sampled on negedge.
`timescale 1ns/100ps
module tb_uart_rx_param;

  localparam int TICK_DIV = 8;
  localparam int BIT_CLK  = 16 * TICK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic [7:0] data0, data1;
  logic [6:0] data2;
  logic v0, pe0, fe0, b0;
  logic v1, pe1, fe1, b1;
  logic v2, pe2, fe2, b2;

  int n_vec = 0;
  int n_err = 0;
  int nv1 = 0, nv2 = 0, wide = 0;
  logic v0_prev = 1'b0;
  logic [9:0] cap0[$];

  uart_rx_param u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_rx(rx0),
    .o_data(data0), .o_valid(v0), .o_parity_err(pe0), .o_frame_err(fe0), .o_busy(b0)
  );

  uart_rx_param #(.PARITY(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_rx(rx1),
    .o_data(data1), .o_valid(v1), .o_parity_err(pe1), .o_frame_err(fe1), .o_busy(b1)
  );

  uart_rx_param #(.NB_DATA(7), .PARITY(2), .N_STOP(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_rx(rx2),
    .o_data(data2), .o_valid(v2), .o_parity_err(pe2), .o_frame_err(fe2), .o_busy(b2)
  );

  always #0.5 clk = ~clk;

  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #0.2;
      tick = (c == TICK_DIV - 1);
      c = (c == TICK_DIV - 1) ? 0 : c + 1;
    end
  end

  always @(negedge clk) begin
    if (v0) cap0.push_back({fe0, pe0, data0});
    if (v0 && v0_prev) wide <= wide + 1;
    v0_prev <= v0;
    if (v1) nv1 <= nv1 + 1;
    if (v2) nv2 <= nv2 + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] cap_at(input int i);
    if (i < cap0.size()) return cap0[i];
    return '1;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #0.2;
  endtask

  task automatic set_rx(input int w, input logic v);
    case (w)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Slot 0 is the start bit; abort_slot >= 0 pulses reset mid-slot and releases the line high.
  task automatic send_frame(input int w, input logic [8:0] d, input int nb, input int has_par,
                            input logic pbit, input int nstop, input logic [1:0] stops,
                            input int abort_slot);
    logic [15:0] seq;
    int n;
    seq = '0;
    for (int i = 0; i < nb; i++) seq[1 + i] = d[i];
    n = 1 + nb;
    if (has_par != 0) begin
      seq[n] = pbit;
      n = n + 1;
    end
    for (int i = 0; i < nstop; i++) seq[n + i] = stops[i];
    n = n + nstop;
    for (int s = 0; s < n; s++) begin
      set_rx(w, seq[s]);
      if (s == abort_slot) begin
        wait_clks(BIT_CLK / 2);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        set_rx(w, 1'b1);
        return;
      end
      wait_clks(BIT_CLK);
    end
  endtask

  initial begin
    int base;
    rst = 1'b1;
    wait_clks(4);
    @(negedge clk);
    check_val("rst_data", data0, 0);
    check_val("rst_valid", v0, 0);
    check_val("rst_perr", pe0, 0);
    check_val("rst_ferr", fe0, 0);
    check_val("rst_busy", b0, 0);
    wait_clks(1);
    rst = 1'b0;
    wait_clks(BIT_CLK);

    base = cap0.size();
    send_frame(0, 9'h053, 8, 0, 1'b0, 1, 2'b11, -1);
    wait_clks(4);
    @(negedge clk);
    check_val("single_count", cap0.size() - base, 1);
    check_val("single_word", cap_at(base), 10'h053);
    check_val("single_data_hold", data0, 8'h53);

    base = cap0.size();
    send_frame(0, 9'h053, 8, 0, 1'b0, 1, 2'b11, -1);
    send_frame(0, 9'h02B, 8, 0, 1'b0, 1, 2'b11, -1);
    send_frame(0, 9'h001, 8, 0, 1'b0, 1, 2'b11, -1);
    wait_clks(4);
    @(negedge clk);
    check_val("b2b_count", cap0.size() - base, 3);
    check_val("b2b_word0", cap_at(base), 10'h053);
    check_val("b2b_word1", cap_at(base + 1), 10'h02B);
    check_val("b2b_word2", cap_at(base + 2), 10'h001);

    base = cap0.size();
    set_rx(0, 1'b0);
    wait_clks(6);
    @(negedge clk);
    check_val("glitch_busy_high", b0, 1);
    wait_clks(6);
    set_rx(0, 1'b1);
    wait_clks(90);
    @(negedge clk);
    check_val("glitch_busy_low", b0, 0);
    check_val("glitch_no_valid", cap0.size() - base, 0);

    base = cap0.size();
    send_frame(0, 9'h02B, 8, 0, 1'b0, 1, 2'b00, -1);
    wait_clks(2 * BIT_CLK);
    @(negedge clk);
    check_val("ferr_count", cap0.size() - base, 1);
    check_val("ferr_word", cap_at(base), 10'h22B);
    check_val("ferr_flag_hold", fe0, 1);
    check_val("ferr_break_not_busy", b0, 0);
    set_rx(0, 1'b1);
    wait_clks(BIT_CLK);
    base = cap0.size();
    send_frame(0, 9'h001, 8, 0, 1'b0, 1, 2'b11, -1);
    wait_clks(4);
    @(negedge clk);
    check_val("recover_count", cap0.size() - base, 1);
    check_val("recover_word", cap_at(base), 10'h001);
    check_val("recover_ferr", fe0, 0);

    base = cap0.size();
    send_frame(0, 9'h053, 8, 0, 1'b0, 1, 2'b11, 5);
    @(negedge clk);
    check_val("midrst_data", data0, 0);
    check_val("midrst_valid", v0, 0);
    check_val("midrst_perr", pe0, 0);
    check_val("midrst_ferr", fe0, 0);
    check_val("midrst_busy", b0, 0);
    wait_clks(3 * BIT_CLK);
    @(negedge clk);
    check_val("midrst_no_valid", cap0.size() - base, 0);
    send_frame(0, 9'h053, 8, 0, 1'b0, 1, 2'b11, -1);
    wait_clks(4);
    @(negedge clk);
    check_val("midrst_next_count", cap0.size() - base, 1);
    check_val("midrst_next_word", cap_at(base), 10'h053);

    send_frame(1, 9'h053, 8, 1, 1'b0, 1, 2'b11, -1);
    wait_clks(4);
    @(negedge clk);
    check_val("even_ok_count", nv1, 1);
    check_val("even_ok_perr", pe1, 0);
    check_val("even_ok_data", data1, 8'h53);
    send_frame(1, 9'h053, 8, 1, 1'b1, 1, 2'b11, -1);
    wait_clks(4);
    @(negedge clk);
    check_val("even_bad_count", nv1, 2);
    check_val("even_bad_perr", pe1, 1);
    check_val("even_bad_ferr", fe1, 0);

    send_frame(2, 9'h02B, 7, 1, 1'b1, 2, 2'b11, -1);
    wait_clks(4);
    @(negedge clk);
    check_val("odd_ok_count", nv2, 1);
    check_val("odd_ok_flags", {pe2, fe2}, 2'b00);
    check_val("odd_ok_data", data2, 7'h2B);
    send_frame(2, 9'h02B, 7, 1, 1'b1, 2, 2'b01, -1);
    set_rx(2, 1'b1);
    wait_clks(4);
    @(negedge clk);
    check_val("stop2_count", nv2, 2);
    check_val("stop2_flags", {pe2, fe2}, 2'b01);
    check_val("stop2_data", data2, 7'h2B);

    check_val("valid_width", wide, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
